// File: rtl/execute_stage_pkg.sv
// -----------------------------------------------------------------------------
// execute_stage_pkg
// Shared definitions for the FDE core execute stage:
//   - ID_EX (176 bit) and EX_MEM (108 bit) bundle layouts as packed structs
//   - ALU_OP, FUNCT and OPCODE codes
//   - multiplier FSM state encoding
//   - two's-complement add overflow helper
// -----------------------------------------------------------------------------
package execute_stage_pkg;

    localparam int unsigned ID_EX_W  = 176;
    localparam int unsigned EX_MEM_W = 108;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_ITYPE = 2'b11
    } alu_op_e;

    typedef enum logic [5:0] {
        F_SLL   = 6'h00,
        F_SRL   = 6'h02,
        F_SRA   = 6'h03,
        F_MFHI  = 6'h10,
        F_MFLO  = 6'h12,
        F_MULT  = 6'h18,
        F_MULTU = 6'h19,
        F_ADD   = 6'h20,
        F_ADDU  = 6'h21,
        F_SUB   = 6'h22,
        F_SUBU  = 6'h23,
        F_AND   = 6'h24,
        F_OR    = 6'h25,
        F_XOR   = 6'h26,
        F_NOR   = 6'h27,
        F_SLT   = 6'h2A,
        F_SLTU  = 6'h2B
    } funct_e;

    typedef enum logic [5:0] {
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F
    } opcode_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm_sext;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [5:0]  opcode;
        logic        reg_dst;
        logic        alu_src;
        logic [1:0]  alu_op;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        mem_to_reg;
        logic        reg_write;
        logic        valid;
        logic [10:0] reserved;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [31:0] branch_target;
        logic        zero;
        logic [4:0]  write_reg;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        mem_to_reg;
        logic        reg_write;
        logic        valid;
    } ex_mem_t;

    // Signed overflow of s = a + b. For a - b pass ~b as the second operand.
    function automatic logic add_ovf(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input logic [31:0] s);
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

endpackage

// File: rtl/execute_stage_iter_multiplier.sv
// -----------------------------------------------------------------------------
// iter_multiplier
// Iterative shift-add 32x32 multiplier writing a 64-bit product into HI/LO.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   start_i           accepted only in IDLE; latches a_i/b_i/signed_i
//   signed_i          1 = MULT (signed), 0 = MULTU
//   a_i, b_i          operands
//   state_o           FSM state (IDLE/BUSY/DONE), registered
//   hi_o, lo_o        product registers, updated only on the final iteration
// -----------------------------------------------------------------------------
module iter_multiplier
    import execute_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output mul_state_e      state_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int unsigned CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

    mul_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [2*XLEN-1:0] acc_q;
    logic              neg_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;

    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] acc_d;

    // Signed multiply runs on magnitudes; -2^31 maps to 2^31 unsigned, which fits.
    always_comb begin
        mag_a = (signed_i && a_i[XLEN-1]) ? -a_i : a_i;
        mag_b = (signed_i && b_i[XLEN-1]) ? -b_i : b_i;
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (start_i) begin
                        mcand_q  <= {{XLEN{1'b0}}, mag_a};
                        mplier_q <= mag_b;
                        acc_q    <= '0;
                        neg_q    <= signed_i && (a_i[XLEN-1] ^ b_i[XLEN-1]);
                        cnt_q    <= '0;
                        state_q  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    cnt_q    <= cnt_q + CNT_W'(1);
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    acc_q    <= acc_d;
                    if (cnt_q == LAST) begin
                        {hi_q, lo_q} <= neg_q ? -acc_d : acc_d;
                        state_q      <= MUL_DONE;
                    end
                end
                MUL_DONE: state_q <= MUL_IDLE;
                default:  state_q <= MUL_IDLE;
            endcase
        end
    end

    assign state_o = state_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
// Third stage of the FDE core: ALU, shifts, branch target/zero, and iterative
// MULT/MULTU into HI/LO. Result registered into the EX_MEM bundle.
// Ports:
//   CLOCK   rising-edge clock
//   RESET   asynchronous, active-low
//   ID_EX   176-bit decoded bundle from fetch_decode
//   STALL   combinational; high while a multiply is being accepted/computed
//   OVF     registered overflow pulse (constant 0 unless EXECUTE_OVF_TRAP_EN)
//   EX_MEM  108-bit registered result bundle
// Optional: `define EXECUTE_OVF_TRAP_EN to trap signed ADD/SUB/ADDI overflow.
// -----------------------------------------------------------------------------
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [ID_EX_W-1:0]  ID_EX,
    output logic                STALL,
    output logic                OVF,
    output logic [EX_MEM_W-1:0] EX_MEM
);

    id_ex_t      id;
    ex_mem_t     ex_q;
    ex_mem_t     ex_d;
    mul_state_e  mul_state;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic        is_mul;
    logic        mul_start;
    logic [31:0] op_b;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] alu_res;
    logic [4:0]  wr_reg;
    logic [31:0] br_tgt;
    logic        unused_bits;

    assign id          = id_ex_t'(ID_EX);
    assign unused_bits = ^id.reserved;

    assign is_mul    = id.valid && (id.alu_op == ALU_RTYPE) &&
                       ((id.funct == F_MULT) || (id.funct == F_MULTU));
    assign mul_start = is_mul && (mul_state == MUL_IDLE);
    assign STALL     = RESET && (mul_start || (mul_state == MUL_BUSY));

    iter_multiplier #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk_i    (CLOCK),
        .rst_ni   (RESET),
        .start_i  (mul_start),
        .signed_i (id.funct == F_MULT),
        .a_i      (id.rd1),
        .b_i      (id.rd2),
        .state_o  (mul_state),
        .hi_o     (mul_hi),
        .lo_o     (mul_lo)
    );

    always_comb begin
        op_b    = id.alu_src ? id.imm_sext : id.rd2;
        sum     = id.rd1 + op_b;
        diff    = id.rd1 - op_b;
        wr_reg  = id.reg_dst ? id.rd : id.rt;
        br_tgt  = id.pc_plus4 + (id.imm_sext << 2);
        alu_res = '0;
        case (id.alu_op)
            ALU_ADD: alu_res = sum;
            ALU_SUB: alu_res = diff;
            ALU_ITYPE: begin
                case (id.opcode)
                    OP_ADDI, OP_ADDIU: alu_res = sum;
                    OP_ANDI: alu_res = id.rd1 & {16'h0000, id.imm_sext[15:0]};
                    OP_ORI:  alu_res = id.rd1 | {16'h0000, id.imm_sext[15:0]};
                    OP_SLTI: alu_res = {31'b0, $signed(id.rd1) < $signed(op_b)};
                    OP_LUI:  alu_res = {id.imm_sext[15:0], 16'h0000};
                    default: alu_res = '0;
                endcase
            end
            ALU_RTYPE: begin
                case (id.funct)
                    F_ADD, F_ADDU: alu_res = sum;
                    F_SUB, F_SUBU: alu_res = diff;
                    F_AND:  alu_res = id.rd1 & op_b;
                    F_OR:   alu_res = id.rd1 | op_b;
                    F_XOR:  alu_res = id.rd1 ^ op_b;
                    F_NOR:  alu_res = ~(id.rd1 | op_b);
                    F_SLT:  alu_res = {31'b0, $signed(id.rd1) < $signed(op_b)};
                    F_SLTU: alu_res = {31'b0, id.rd1 < op_b};
                    F_SLL:  alu_res = op_b << id.shamt;
                    F_SRL:  alu_res = op_b >> id.shamt;
                    F_SRA:  alu_res = $signed(op_b) >>> id.shamt;
                    F_MFHI: alu_res = mul_hi;
                    F_MFLO: alu_res = mul_lo;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

`ifdef EXECUTE_OVF_TRAP_EN
    logic ovf_det;
    logic ovf_d;
    logic ovf_q;

    always_comb begin
        ovf_det = 1'b0;
        if (id.alu_op == ALU_RTYPE && id.funct == F_ADD)
            ovf_det = add_ovf(id.rd1, op_b, sum);
        else if (id.alu_op == ALU_RTYPE && id.funct == F_SUB)
            ovf_det = add_ovf(id.rd1, ~op_b, diff);
        else if (id.alu_op == ALU_ITYPE && id.opcode == OP_ADDI)
            ovf_det = add_ovf(id.rd1, op_b, sum);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign OVF = ovf_q;
`else
    assign OVF = 1'b0;
`endif

    // DONE relies on upstream still holding the multiply, so its control
    // fields are taken from ID_EX while the result comes from LO.
    always_comb begin
        ex_d = '0;
`ifdef EXECUTE_OVF_TRAP_EN
        ovf_d = 1'b0;
`endif
        if (mul_state == MUL_DONE) begin
            ex_d.alu_result    = mul_lo;
            ex_d.store_data    = id.rd2;
            ex_d.branch_target = br_tgt;
            ex_d.zero          = (mul_lo == '0);
            ex_d.write_reg     = wr_reg;
            ex_d.mem_read      = id.mem_read;
            ex_d.mem_write     = id.mem_write;
            ex_d.branch        = id.branch;
            ex_d.mem_to_reg    = id.mem_to_reg;
            ex_d.reg_write     = 1'b0;
            ex_d.valid         = 1'b1;
        end else if (mul_state == MUL_IDLE && id.valid && !is_mul) begin
            ex_d.alu_result    = alu_res;
            ex_d.store_data    = id.rd2;
            ex_d.branch_target = br_tgt;
            ex_d.zero          = (alu_res == '0);
            ex_d.write_reg     = wr_reg;
            ex_d.mem_read      = id.mem_read;
            ex_d.mem_write     = id.mem_write;
            ex_d.branch        = id.branch;
            ex_d.mem_to_reg    = id.mem_to_reg;
            ex_d.reg_write     = id.reg_write;
            ex_d.valid         = 1'b1;
`ifdef EXECUTE_OVF_TRAP_EN
            if (ovf_det) begin
                ex_d.reg_write = 1'b0;
                ex_d.mem_read  = 1'b0;
                ex_d.mem_write = 1'b0;
                ovf_d          = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign EX_MEM = ex_q;

endmodule
